// File: rtl/barrett_2861_arbiter.sv
// Round-robin front end feeding a 3-stage modulo-2861 Barrett reduction pipeline.
// Each residue leaves tagged with the index of the requester that issued its operand.
module barrett_2861_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [NUM_REQ*23-1:0] req_data,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic                  out_valid,
  output logic [11:0]           out_data,
  output logic [ID_W-1:0]       out_id,
  input  logic                  out_ready,
  output logic                  busy
);

  localparam logic [23:0] Modulus = 24'd2861;
  localparam logic [23:0] Mu      = 24'd5864;  // floor(2^24 / 2861)

  logic            adv;
  logic            found;
  logic            take;
  logic [ID_W-1:0] winner;
  logic [ID_W-1:0] ptr_q, ptr_d;
  logic [22:0]     a_in;
  int unsigned     idx;

  logic            s1_valid_q;
  logic [22:0]     s1_a_q;
  logic [ID_W-1:0] s1_id_q;

  logic            s2_valid_q;
  logic [22:0]     s2_a_q;
  logic [11:0]     s2_t_q;
  logic [ID_W-1:0] s2_id_q;

  logic            out_valid_q;
  logic [11:0]     out_data_q;
  logic [ID_W-1:0] out_id_q;

  logic [23:0]     qh;
  logic [11:0]     t;
  logic [23:0]     m;
  logic [23:0]     r0, r1, r2;

  assign adv = !out_valid_q || out_ready;

  // Search from the pointer upwards; the first valid requester wins.
  always_comb begin
    found     = 1'b0;
    winner    = '0;
    idx       = 0;
    req_ready = '0;
    a_in      = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = (32'(ptr_q) + k) % NUM_REQ;
      if (!found && req_valid[idx]) begin
        found  = 1'b1;
        winner = ID_W'(idx);
      end
    end
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (ID_W'(i) == winner) begin
        a_in = req_data[23*i +: 23];
      end
    end
    take = found && adv && !rst;
    if (take) begin
      req_ready[winner] = 1'b1;
    end
    ptr_d = (winner == ID_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
  end

  // Quotient estimate from the top 11 bits, then subtract and correct twice.
  always_comb begin
    qh = 24'(s1_a_q[22:12]) * Mu;
    t  = 12'(qh >> 12);
    m  = 24'(s2_t_q) * Modulus;
    r0 = {1'b0, s2_a_q} - m;
    r1 = (r0 >= Modulus) ? r0 - Modulus : r0;
    r2 = (r1 >= Modulus) ? r1 - Modulus : r1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q       <= '0;
      s1_valid_q  <= 1'b0;
      s2_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_id_q    <= '0;
    end else begin
      if (take) begin
        ptr_q <= ptr_d;
      end
      if (adv) begin
        s1_valid_q  <= take;
        s2_valid_q  <= s1_valid_q;
        out_valid_q <= s2_valid_q;
        if (s2_valid_q) begin
          out_data_q <= 12'(r2);
          out_id_q   <= s2_id_q;
        end
      end
    end
  end

  // Datapath registers need no reset; their valids gate them.
  always_ff @(posedge clk) begin
    if (adv) begin
      if (take) begin
        s1_a_q  <= a_in;
        s1_id_q <= winner;
      end
      if (s1_valid_q) begin
        s2_a_q  <= s1_a_q;
        s2_t_q  <= t;
        s2_id_q <= s1_id_q;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_id    = out_id_q;
  assign busy      = s1_valid_q || s2_valid_q || out_valid_q;

endmodule

// File: tb/tb_barrett_2861_arbiter.sv
// Self-checking bench: arbitration model plus result scoreboard, with directed and random tests.
module tb_barrett_2861_arbiter;
  localparam int NR = 4;
  localparam int IW = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic [NR-1:0]    req_valid;
  logic [NR*23-1:0] req_data;
  logic [NR-1:0]    req_ready;
  logic             out_valid;
  logic [11:0]      out_data;
  logic [IW-1:0]    out_id;
  logic             out_ready;
  logic             busy;

  barrett_2861_arbiter #(.NUM_REQ(NR), .ID_W(IW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_id    (out_id),
    .out_ready (out_ready),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [IW-1:0] id;
    logic [11:0]   data;
  } exp_t;

  exp_t          exp_q[$];
  int            n_checks = 0;
  int            n_fail   = 0;
  int            ptr_m    = 0;
  logic [NR-1:0] acc_mask = '0;

  // Mid-cycle monitor: predicts grants, pushes expected residues, pops on output handshake.
  always @(negedge clk) begin
    exp_t          e;
    logic [NR-1:0] exp_rdy;
    logic [22:0]   a;
    int            win;
    int            idx;
    bit            found;
    bit            adv_m;
    if (rst) begin
      exp_q.delete();
      ptr_m    = 0;
      acc_mask = '0;
      n_checks++;
      if (req_ready !== '0) begin
        n_fail++;
        $display("FAIL ready_in_reset: got %b expected 0000", req_ready);
      end
    end else begin
      if (out_valid === 1'b1 && out_ready) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL sb_unexpected: got id=%0d data=%0d expected no result", out_id, out_data);
        end else begin
          e = exp_q.pop_front();
          if (out_id !== e.id || out_data !== e.data) begin
            n_fail++;
            $display("FAIL sb_result: got id=%0d data=%0d expected id=%0d data=%0d",
                     out_id, out_data, e.id, e.data);
          end
        end
      end
      adv_m   = (out_valid !== 1'b1) || out_ready;
      exp_rdy = '0;
      found   = 0;
      win     = 0;
      for (int k = 0; k < NR; k++) begin
        idx = (ptr_m + k) % NR;
        if (!found && req_valid[idx]) begin
          found = 1;
          win   = idx;
        end
      end
      if (found && adv_m) exp_rdy[win] = 1'b1;
      n_checks++;
      if (req_ready !== exp_rdy) begin
        n_fail++;
        $display("FAIL grant: got %b expected %b", req_ready, exp_rdy);
      end
      acc_mask = req_valid & exp_rdy;
      if (found && adv_m) begin
        a      = req_data[23*win +: 23];
        e.id   = IW'(win);
        e.data = 12'(a % 23'd2861);
        exp_q.push_back(e);
        ptr_m  = (win + 1) % NR;
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic do_reset();
    @(posedge clk); #1;
    rst       = 1'b1;
    req_valid = '0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic drain();
    int cyc = 0;
    @(posedge clk); #1;
    req_valid = '0;
    out_ready = 1'b1;
    while ((exp_q.size() != 0 || busy) && cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
    end
    n_checks++;
    if (exp_q.size() != 0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL drain: got pending=%0d busy=%b expected 0 and 0", exp_q.size(), busy);
    end
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    rst       = 1'b1;
    req_valid = '1;
    @(negedge clk);
    n_checks++;
    if (req_ready !== '0) begin
      n_fail++;
      $display("FAIL reset_ready: got %b expected 0000", req_ready);
    end
    @(posedge clk); #1;
    req_valid = '0;
    rst       = 1'b0;
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || out_data !== 12'd0 || out_id !== 2'd0 ||
        req_ready !== '0) begin
      n_fail++;
      $display("FAIL reset_state: got v=%b busy=%b d=%0d id=%0d rdy=%b expected 0 0 0 0 0000",
               out_valid, busy, out_data, out_id, req_ready);
    end
  endtask

  task automatic test_single();
    @(posedge clk); #1;
    req_valid       = 4'b0100;
    req_data[46+:23] = 23'd2860;
    @(negedge clk);
    n_checks++;
    if (req_ready !== 4'b0100) begin
      n_fail++;
      $display("FAIL single_ready: got %b expected 0100", req_ready);
    end
    @(posedge clk); #1;
    req_valid = '0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL single_early: got out_valid=%b expected 0 at cycle %0d", out_valid, c);
      end
    end
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== 12'd2860 || out_id !== 2'd2) begin
      n_fail++;
      $display("FAIL single_result: got v=%b d=%0d id=%0d expected 1 2860 2",
               out_valid, out_data, out_id);
    end
  endtask

  task automatic test_directed();
    logic [22:0] ins[6];
    logic [11:0] outs[6];
    ins  = '{23'd0, 23'd2861, 23'd5722, 23'd8185320, 23'd8388607, 23'd12345};
    outs = '{12'd0, 12'd0, 12'd0, 12'd2860, 12'd155, 12'd901};
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          @(posedge clk); #1;
          req_valid       = 4'b0001;
          req_data[0+:23] = ins[i];
        end
        @(posedge clk); #1;
        req_valid = '0;
      end
      begin
        int n = 0;
        for (int c = 0; c < 40 && n < 6; c++) begin
          @(negedge clk);
          if (out_valid === 1'b1) begin
            n_checks++;
            if (out_data !== outs[n] || out_id !== 2'd0) begin
              n_fail++;
              $display("FAIL directed_%0d: got d=%0d id=%0d expected d=%0d id=0",
                       n, out_data, out_id, outs[n]);
            end
            n++;
          end
        end
        n_checks++;
        if (n != 6) begin
          n_fail++;
          $display("FAIL directed_count: got %0d results expected 6", n);
        end
      end
    join
  endtask

  task automatic test_round_robin();
    int c = 0;
    do_reset();
    out_ready = 1'b1;
    @(posedge clk); #1;
    req_valid = '1;
    for (int i = 0; i < NR; i++) req_data[23*i +: 23] = 23'(1000 * i + 7);
    @(negedge clk);
    while (out_valid !== 1'b1 && c < 10) begin
      @(negedge clk);
      c++;
    end
    for (int k = 0; k < 8; k++) begin
      n_checks++;
      if (out_valid !== 1'b1 || out_id !== IW'(k % NR)) begin
        n_fail++;
        $display("FAIL rr_seq_%0d: got v=%b id=%0d expected v=1 id=%0d",
                 k, out_valid, out_id, k % NR);
      end
      @(negedge clk);
    end
    @(posedge clk); #1;
    req_valid = '0;
  endtask

  task automatic test_no_starve();
    logic [NR-1:0] want;
    do_reset();
    out_ready = 1'b1;
    @(posedge clk); #1;
    req_valid       = 4'b0001;
    req_data[0+:23] = 23'd4000000;
    req_data[69+:23] = 23'd3000000;
    @(posedge clk); #1;
    req_valid = 4'b1001;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      want = (k % 2 == 0) ? 4'b1000 : 4'b0001;
      n_checks++;
      if (req_ready !== want) begin
        n_fail++;
        $display("FAIL starve_%0d: got %b expected %b", k, req_ready, want);
      end
    end
    @(posedge clk); #1;
    req_valid = '0;
  endtask

  task automatic test_stall();
    int          sent = 0;
    logic [11:0] snap_d;
    logic [1:0]  snap_id;
    for (int c = 0; c < 16; c++) begin
      @(posedge clk); #1;
      if (acc_mask[1]) sent++;
      if (sent < 6) begin
        req_valid[1]     = 1'b1;
        req_data[23+:23] = 23'(100003 * (sent + 1));
      end else begin
        req_valid[1] = 1'b0;
      end
      out_ready = !(c >= 4 && c < 9);
      @(negedge clk);
      if (!out_ready) begin
        n_checks++;
        if (c == 4) begin
          snap_d  = out_data;
          snap_id = out_id;
          if (out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_valid: got %b expected 1", out_valid);
          end
        end else if (out_valid !== 1'b1 || out_data !== snap_d || out_id !== snap_id) begin
          n_fail++;
          $display("FAIL stall_hold_%0d: got v=%b d=%0d id=%0d expected 1 %0d %0d",
                   c, out_valid, out_data, out_id, snap_d, snap_id);
        end
        n_checks++;
        if (req_ready !== '0) begin
          n_fail++;
          $display("FAIL stall_ready_%0d: got %b expected 0000", c, req_ready);
        end
      end
    end
  endtask

  task automatic test_reset_inflight();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      req_valid        = 4'b0100;
      req_data[46+:23] = 23'(777777 * (i + 1));
    end
    @(posedge clk); #1;
    rst       = 1'b1;
    req_valid = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL stale_%0d: got v=%b busy=%b expected 0 0", c, out_valid, busy);
      end
    end
    @(posedge clk); #1;
    req_valid = '1;
    for (int i = 0; i < NR; i++) req_data[23*i +: 23] = 23'(5000000 + i);
    @(negedge clk);
    n_checks++;
    if (req_ready !== 4'b0001) begin
      n_fail++;
      $display("FAIL ptr_after_reset: got %b expected 0001", req_ready);
    end
    @(posedge clk); #1;
    req_valid = '0;
  endtask

  task automatic test_random();
    int issued = 0;
    int cyc    = 0;
    while ((issued < 10000 || req_valid != '0) && cyc < 60000) begin
      @(posedge clk); #1;
      for (int i = 0; i < NR; i++) begin
        if (!req_valid[i] || acc_mask[i]) begin
          if (issued < 10000 && $urandom_range(0, 1) == 1) begin
            req_valid[i] = 1'b1;
            case ($urandom_range(0, 7))
              0:       req_data[23*i +: 23] = 23'd8388607;
              1:       req_data[23*i +: 23] = 23'(2861 * $urandom_range(0, 2932));
              2:       req_data[23*i +: 23] = 23'(2861 * $urandom_range(1, 2932) - 1);
              default: req_data[23*i +: 23] = 23'($urandom_range(0, 8388607));
            endcase
            issued++;
          end else begin
            req_valid[i] = 1'b0;
          end
        end
      end
      out_ready = ($urandom_range(0, 3) != 0);
      cyc++;
    end
    n_checks++;
    if (cyc >= 60000) begin
      n_fail++;
      $display("FAIL random_budget: got %0d issued in %0d cycles expected 10000", issued, cyc);
    end
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = '0;
    req_data  = '0;
    out_ready = 1'b1;
    test_reset();
    test_single();
    drain();
    test_directed();
    drain();
    test_round_robin();
    drain();
    test_no_starve();
    drain();
    test_stall();
    drain();
    test_reset_inflight();
    drain();
    test_random();
    drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
